sram_ctrl: RTL and testbench

Responder side of the LSU memory handshake. It accepts one 32-bit load or store request on the VALID/READY interface and executes it as two 16-bit accesses on the external asynchronous SRAM (256K x 16). It returns a one-cycle READY pulse, with the read data valid in the same cycle. The block sits between the LSU address decode and the SRAM pins.

---
 rtl/sram_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: LSU responder that turns one 32-bit load/store request into two
// 16-bit accesses on an external asynchronous 256K x 16 SRAM. Every SRAM pin
// and o_READY comes straight from a flop; the flops are loaded from the
// decode of the next state, so pins change on the same edge as the state.
// Store halves whose byte strobes are all zero are skipped entirely.

module sram_ctrl #(
  parameter int WAIT_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_VALID,
  output logic        o_READY,
  input  logic [31:0] i_addr,
  input  logic        i_wren,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_strb,
  output logic [31:0] o_rdata,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP_LO = 3'd1,
    ST_STRB_LO  = 3'd2,
    ST_SETUP_HI = 3'd3,
    ST_STRB_HI  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Final value of the strobe counter (it counts 0 .. WAIT_CYC-1).
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

  // Select the 16-bit half of a 32-bit word (hi = upper half).
  function automatic logic [15:0] half_word(input logic [31:0] w, input logic hi);
    logic [15:0] r;
    if (hi) begin
      r = w[31:16];
    end else begin
      r = w[15:0];
    end
    return r;
  endfunction

  // Select the two byte strobes belonging to one half, returned as {ub, lb}.
  function automatic logic [1:0] half_strb(input logic [3:0] s, input logic hi);
    logic [1:0] r;
    if (hi) begin
      r = s[3:2];
    end else begin
      r = s[1:0];
    end
    return r;
  endfunction

  // Address bits outside the word address are not used by this block.
  logic addr_unused_s;
  assign addr_unused_s = ^{i_addr[31:19], i_addr[1:0]};

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        strb_last_s;

  logic [16:0] addr_r;
  logic        wren_r;
  logic [31:0] wdata_r;
  logic [3:0]  strb_r;

  logic [16:0] req_addr_s;
  logic        req_wren_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_strb_s;

  logic [31:0] rdata_r;
  logic        ready_r;
  logic [17:0] sram_addr_r, sram_addr_nxt_s;
  logic        ce_n_r, ce_n_nxt_s;
  logic        we_n_r, we_n_nxt_s;
  logic        oe_n_r, oe_n_nxt_s;
  logic        lb_n_r, lb_n_nxt_s;
  logic        ub_n_r, ub_n_nxt_s;
  logic        dq_oe_r, dq_oe_nxt_s;
  logic [15:0] dq_out_r, dq_out_nxt_s;
  logic        half_nxt_s;

  assign strb_last_s = (cnt_r == WAIT_LAST);

  // In IDLE the request is taken straight from the inputs (it is being
  // captured on this edge); afterwards the captured copy is used.
  always_comb begin
    req_addr_s  = addr_r;
    req_wren_s  = wren_r;
    req_wdata_s = wdata_r;
    req_strb_s  = strb_r;
    if (state_r == ST_IDLE) begin
      req_addr_s  = i_addr[18:2];
      req_wren_s  = i_wren;
      req_wdata_s = i_wdata;
      req_strb_s  = i_strb;
    end else begin
      req_addr_s  = addr_r;
      req_wren_s  = wren_r;
      req_wdata_s = wdata_r;
      req_strb_s  = strb_r;
    end
  end

  // Next-state and strobe-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (!i_VALID) begin
          state_nxt_s = ST_IDLE;
        end else if (!i_wren || (i_strb[1:0] != 2'b00)) begin
          state_nxt_s = ST_SETUP_LO;
        end else if (i_strb[3:2] != 2'b00) begin
          state_nxt_s = ST_SETUP_HI;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_SETUP_LO: state_nxt_s = ST_STRB_LO;
      ST_STRB_LO: begin
        if (!strb_last_s) begin
          state_nxt_s = ST_STRB_LO;
          cnt_nxt_s   = cnt_r + 4'd1;
        end else if (!wren_r || (strb_r[3:2] != 2'b00)) begin
          state_nxt_s = ST_SETUP_HI;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_SETUP_HI: state_nxt_s = ST_STRB_HI;
      ST_STRB_HI: begin
        if (!strb_last_s) begin
          state_nxt_s = ST_STRB_HI;
          cnt_nxt_s   = cnt_r + 4'd1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // SRAM pin values for the cycle we are about to enter.
  always_comb begin
    sram_addr_nxt_s = sram_addr_r;
    ce_n_nxt_s      = 1'b1;
    we_n_nxt_s      = 1'b1;
    oe_n_nxt_s      = 1'b1;
    lb_n_nxt_s      = 1'b1;
    ub_n_nxt_s      = 1'b1;
    dq_oe_nxt_s     = 1'b0;
    dq_out_nxt_s    = 16'h0000;
    half_nxt_s      = (state_nxt_s == ST_SETUP_HI) || (state_nxt_s == ST_STRB_HI);
    case (state_nxt_s)
      ST_SETUP_LO, ST_STRB_LO, ST_SETUP_HI, ST_STRB_HI: begin
        ce_n_nxt_s      = 1'b0;
        sram_addr_nxt_s = {req_addr_s, half_nxt_s};
        if (req_wren_s) begin
          dq_oe_nxt_s              = 1'b1;
          dq_out_nxt_s             = half_word(req_wdata_s, half_nxt_s);
          {ub_n_nxt_s, lb_n_nxt_s} = ~half_strb(req_strb_s, half_nxt_s);
        end else begin
          lb_n_nxt_s = 1'b0;
          ub_n_nxt_s = 1'b0;
        end
        // Strobe only in STRB; the setup cycle keeps OE_N high so the
        // SRAM never drives DQ while we may still be driving it.
        if ((state_nxt_s == ST_STRB_LO) || (state_nxt_s == ST_STRB_HI)) begin
          we_n_nxt_s = ~req_wren_s;
          oe_n_nxt_s = req_wren_s;
        end else begin
          we_n_nxt_s = 1'b1;
          oe_n_nxt_s = 1'b1;
        end
      end
      default: begin
        ce_n_nxt_s  = 1'b1;
        dq_oe_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter and registered SRAM/handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      ready_r     <= 1'b0;
      sram_addr_r <= 18'd0;
      ce_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      lb_n_r      <= 1'b1;
      ub_n_r      <= 1'b1;
      dq_oe_r     <= 1'b0;
      dq_out_r    <= 16'h0000;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ready_r     <= (state_nxt_s == ST_DONE);
      sram_addr_r <= sram_addr_nxt_s;
      ce_n_r      <= ce_n_nxt_s;
      we_n_r      <= we_n_nxt_s;
      oe_n_r      <= oe_n_nxt_s;
      lb_n_r      <= lb_n_nxt_s;
      ub_n_r      <= ub_n_nxt_s;
      dq_oe_r     <= dq_oe_nxt_s;
      dq_out_r    <= dq_out_nxt_s;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r  <= 17'd0;
      wren_r  <= 1'b0;
      wdata_r <= 32'd0;
      strb_r  <= 4'd0;
    end else if ((state_r == ST_IDLE) && i_VALID) begin
      addr_r  <= i_addr[18:2];
      wren_r  <= i_wren;
      wdata_r <= i_wdata;
      strb_r  <= i_strb;
    end else begin
      addr_r  <= addr_r;
      wren_r  <= wren_r;
      wdata_r <= wdata_r;
      strb_r  <= strb_r;
    end
  end

  // Sample load data on the closing edge of the last strobe cycle of each half.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_r <= 32'd0;
    end else if ((state_r == ST_STRB_LO) && strb_last_s && !wren_r) begin
      rdata_r[15:0] <= SRAM_DQ;
    end else if ((state_r == ST_STRB_HI) && strb_last_s && !wren_r) begin
      rdata_r[31:16] <= SRAM_DQ;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;
  assign o_READY   = ready_r;
  assign o_rdata   = rdata_r;
  assign SRAM_ADDR = sram_addr_r;
  assign SRAM_CE_N = ce_n_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_OE_N = oe_n_r;
  assign SRAM_LB_N = lb_n_r;
  assign SRAM_UB_N = ub_n_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with WAIT_CYC=1 and a small
// asynchronous SRAM model (byte-lane writes while CE_N/WE_N low, reads drive
// DQ while CE_N/OE_N low).

module tb_sram_ctrl;

  localparam int WAIT_CYC = 1;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_VALID = 1'b0;
  logic        i_wren = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic [3:0]  i_strb = 4'd0;
  logic        o_READY;
  logic [31:0] o_rdata;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N;

  int n_cmp = 0;
  int n_err = 0;

  // Per-run observations, indexed by cycle number (cycle 0 = request seen).
  int          ready_cyc;
  int          ready_cnt;
  logic [31:0] ce_mask, we_mask, oe_mask, rdy_mask;
  logic [17:0] rec_addr [0:31];
  logic        rec_lb   [0:31];
  logic        rec_ub   [0:31];

  logic [15:0] mem [0:262143];

  sram_ctrl #(.WAIT_CYC(WAIT_CYC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_VALID(i_VALID), .o_READY(o_READY),
    .i_addr(i_addr), .i_wren(i_wren), .i_wdata(i_wdata), .i_strb(i_strb),
    .o_rdata(o_rdata), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N)
  );

  always #5 i_clk = ~i_clk;

  // SRAM read side.
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

  // SRAM write side, sampled mid-cycle while the strobe is stable.
  always @(negedge i_clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Issue one request from IDLE and record 20 cycles of pin activity.
  task automatic run_req(input logic wren, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    i_wren = wren; i_addr = addr; i_wdata = wdata; i_strb = strb; i_VALID = 1'b1;
    ready_cyc = -1; ready_cnt = 0;
    ce_mask = 32'd0; we_mask = 32'd0; oe_mask = 32'd0; rdy_mask = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk); #1;
      rec_addr[c] = SRAM_ADDR; rec_lb[c] = SRAM_LB_N; rec_ub[c] = SRAM_UB_N;
      ce_mask[c] = ~SRAM_CE_N; we_mask[c] = ~SRAM_WE_N; oe_mask[c] = ~SRAM_OE_N;
      rdy_mask[c] = o_READY;
      if (o_READY) begin
        ready_cnt++;
        if (ready_cyc < 0) begin
          ready_cyc = c;
          i_VALID = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", o_READY); end
    n_cmp++; if (o_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 00000000", o_rdata); end
    n_cmp++; if (SRAM_ADDR !== 18'd0) begin n_err++; $display("FAIL reset_addr: got %h want 00000", SRAM_ADDR); end
    n_cmp++; if ({SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N} !== 5'b11111) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 11111", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N}); end
    n_cmp++; if (dut.dq_oe_r !== 1'b0) begin n_err++; $display("FAIL reset_dq_hiz: drive enable %b want 0", dut.dq_oe_r); end
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_store_word();
    run_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    n_cmp++; if (ready_cyc != 5) begin n_err++; $display("FAIL store_word_ready_cyc: got %0d want 5", ready_cyc); end
    n_cmp++; if (ready_cnt != 1) begin n_err++; $display("FAIL store_word_ready_pulses: got %0d want 1", ready_cnt); end
    n_cmp++; if (mem[18'h080] !== 16'hBEEF) begin n_err++; $display("FAIL store_word_lo: got %h want BEEF", mem[18'h080]); end
    n_cmp++; if (mem[18'h081] !== 16'hDEAD) begin n_err++; $display("FAIL store_word_hi: got %h want DEAD", mem[18'h081]); end
    n_cmp++; if (we_mask !== 32'h0000_0014) begin n_err++; $display("FAIL store_word_we: got %h want 00000014", we_mask); end
    n_cmp++; if (ce_mask !== 32'h0000_001E) begin n_err++; $display("FAIL store_word_ce: got %h want 0000001e", ce_mask); end
    n_cmp++; if (rec_addr[3] !== 18'h00081) begin n_err++; $display("FAIL store_word_addr_hi: got %h want 00081", rec_addr[3]); end
  endtask

  task automatic test_load_word();
    run_req(1'b0, 32'h0000_0100, 32'd0, 4'b0000);
    n_cmp++; if (ready_cyc != 5) begin n_err++; $display("FAIL load_word_ready_cyc: got %0d want 5", ready_cyc); end
    n_cmp++; if (o_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_word_data: got %h want deadbeef", o_rdata); end
    n_cmp++; if (oe_mask !== 32'h0000_0014) begin n_err++; $display("FAIL load_word_oe: got %h want 00000014", oe_mask); end
    n_cmp++; if (we_mask !== 32'd0) begin n_err++; $display("FAIL load_word_we: got %h want 00000000", we_mask); end
    n_cmp++; if (rec_addr[1] !== 18'h00080) begin n_err++; $display("FAIL load_word_addr_lo: got %h want 00080", rec_addr[1]); end
  endtask

  task automatic test_byte_store();
    run_req(1'b1, 32'h0000_0102, 32'h00AB_0000, 4'b0100);
    n_cmp++; if (ready_cyc != 3) begin n_err++; $display("FAIL byte_store_ready_cyc: got %0d want 3", ready_cyc); end
    n_cmp++; if (rec_addr[1] !== 18'h00081) begin n_err++; $display("FAIL byte_store_addr: got %h want 00081", rec_addr[1]); end
    n_cmp++; if ({rec_lb[1], rec_ub[1]} !== 2'b01) begin n_err++; $display("FAIL byte_store_lanes: lb/ub %b want 01", {rec_lb[1], rec_ub[1]}); end
    n_cmp++; if (ce_mask !== 32'h0000_0006) begin n_err++; $display("FAIL byte_store_ce: got %h want 00000006", ce_mask); end
    n_cmp++; if (o_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byte_store_rdata_kept: got %h want deadbeef", o_rdata); end
    run_req(1'b0, 32'h0000_0100, 32'd0, 4'b0000);
    n_cmp++; if (o_rdata !== 32'hDEAB_BEEF) begin n_err++; $display("FAIL byte_store_reload: got %h want deabbeef", o_rdata); end
  endtask

  task automatic test_back_to_back();
    i_wren = 1'b1; i_addr = 32'h0000_0100; i_wdata = 32'h1111_1111; i_strb = 4'b0000; i_VALID = 1'b1;
    ce_mask = 32'd0; rdy_mask = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge i_clk); #1;
      ce_mask[c] = ~SRAM_CE_N; rdy_mask[c] = o_READY;
      if (c == 1) begin
        i_wren = 1'b0; i_addr = 32'h0000_0100;
      end
      if (o_READY && (c > 1)) i_VALID = 1'b0;
    end
    i_VALID = 1'b0;
    n_cmp++; if (rdy_mask !== 32'h0000_0082) begin n_err++; $display("FAIL b2b_ready_cycles: got %h want 00000082", rdy_mask); end
    n_cmp++; if (ce_mask !== 32'h0000_0078) begin n_err++; $display("FAIL b2b_ce_cycles: got %h want 00000078", ce_mask); end
    n_cmp++; if (o_rdata !== 32'hDEAB_BEEF) begin n_err++; $display("FAIL b2b_load_data: got %h want deabbeef", o_rdata); end
  endtask

  task automatic test_reset_mid();
    int extra_ready;
    run_req(1'b1, 32'h0000_0200, 32'hAAAA_5555, 4'b1111);
    i_wren = 1'b1; i_addr = 32'h0000_0200; i_wdata = 32'h1234_5678; i_strb = 4'b1111; i_VALID = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    n_cmp++; if ({SRAM_WE_N, SRAM_ADDR} !== {1'b0, 18'h00101}) begin
      n_err++; $display("FAIL rst_mid_in_strb_hi: we_n/addr %b/%h want 0/00101", SRAM_WE_N, SRAM_ADDR); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N} !== 5'b11111) begin
      n_err++; $display("FAIL rst_mid_ctrl: got %b want 11111", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N}); end
    n_cmp++; if ({o_READY, SRAM_ADDR, o_rdata} !== 51'd0) begin
      n_err++; $display("FAIL rst_mid_outputs: ready/addr/rdata %b/%h/%h want 0/00000/00000000", o_READY, SRAM_ADDR, o_rdata); end
    n_cmp++; if (dut.dq_oe_r !== 1'b0) begin n_err++; $display("FAIL rst_mid_dq_hiz: drive enable %b want 0", dut.dq_oe_r); end
    i_VALID = 1'b0;
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    extra_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge i_clk); #1;
      if (o_READY) extra_ready++;
    end
    n_cmp++; if (extra_ready != 0) begin n_err++; $display("FAIL rst_mid_no_ready: got %0d pulses want 0", extra_ready); end
    n_cmp++; if (mem[18'h100] !== 16'h5678) begin n_err++; $display("FAIL rst_mid_lo_written: got %h want 5678", mem[18'h100]); end
    n_cmp++; if (mem[18'h101] !== 16'hAAAA) begin n_err++; $display("FAIL rst_mid_hi_unwritten: got %h want aaaa", mem[18'h101]); end
    run_req(1'b0, 32'h0000_0200, 32'd0, 4'b0000);
    n_cmp++; if (ready_cyc != 5) begin n_err++; $display("FAIL rst_mid_reload_cyc: got %0d want 5", ready_cyc); end
    n_cmp++; if (o_rdata !== 32'hAAAA_5678) begin n_err++; $display("FAIL rst_mid_reload_data: got %h want aaaa5678", o_rdata); end
  endtask

  // Scenario sequence.
  initial begin
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    test_reset();
    test_store_word();
    test_load_word();
    test_byte_store();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
